// File: rtl/rnn_pkg.sv
// Shared RNN widths, vector types and the sequencer state encoding.
// Q(QN.QM) signed elements, BITWIDTH = QN + QM + 1; vectors pack element k at [k*BITWIDTH +: BITWIDTH].
package rnn_pkg;

    // Ceiling log2, never below 1 so it can always size a port.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = n - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned INPUT_SZ        = 8;
    localparam int unsigned HIDDEN_SZ       = 16;
    localparam int unsigned QN              = 6;
    localparam int unsigned QM              = 11;
    localparam int unsigned BITWIDTH        = QN + QM + 1;
    localparam int unsigned INPUT_BITWIDTH  = BITWIDTH * INPUT_SZ;
    localparam int unsigned LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ;
    localparam int unsigned ADDR_BITWIDTH   = clog2(HIDDEN_SZ);
    localparam int unsigned ADDR_BITWIDTH_X = clog2(INPUT_SZ);
    localparam int unsigned COUNT_W         = 16;

    typedef logic [BITWIDTH-1:0]       elem_t;
    typedef logic [INPUT_BITWIDTH-1:0] x_vec_t;
    typedef logic [LAYER_BITWIDTH-1:0] h_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        OUT
    } seq_state_t;

endpackage

// File: rtl/gate_sequencer_if.sv
// Bundle of the sequencer's sample, gate-operand and result handshakes.
// master: the sequencer. slave: upstream source, gate and downstream sink.
interface gate_sequencer_if;

    logic                                   sampleValid;
    rnn_pkg::x_vec_t                        sampleIn;
    logic                                   sampleReady;
    logic                                   clearState;
    logic                                   beginCalc;
    logic                                   dataReady_gate;
    rnn_pkg::h_vec_t                        gateOutput;
    logic [rnn_pkg::ADDR_BITWIDTH_X-1:0]    colAddress_X;
    logic [rnn_pkg::ADDR_BITWIDTH-1:0]      colAddress_Y;
    rnn_pkg::elem_t                         inData;
    rnn_pkg::elem_t                         prevOut;
    logic                                   resultValid;
    rnn_pkg::h_vec_t                        resultOut;
    logic                                   resultReady;
    logic                                   busy;
    logic                                   timeoutErr;
    logic [rnn_pkg::COUNT_W-1:0]            sampleCount;

    modport master (
        input  sampleValid, sampleIn, clearState, dataReady_gate, gateOutput,
               colAddress_X, colAddress_Y, resultReady,
        output sampleReady, beginCalc, inData, prevOut, resultValid, resultOut,
               busy, timeoutErr, sampleCount
    );

    modport slave (
        output sampleValid, sampleIn, clearState, dataReady_gate, gateOutput,
               colAddress_X, colAddress_Y, resultReady,
        input  sampleReady, beginCalc, inData, prevOut, resultValid, resultOut,
               busy, timeoutErr, sampleCount
    );

endinterface

// File: rtl/vector_element_select.sv
// Registered element mux: elem_q <= vec_in[addr], zero for addr >= N.
// Ports: clock, reset (async active-low), vec_in (N packed elements), addr, elem_q.
module vector_element_select #(
    parameter int unsigned N        = 8,
    parameter int unsigned BITWIDTH = 18,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N*BITWIDTH-1:0] vec_in,
    input  logic [ADDR_W-1:0]     addr,
    output logic [BITWIDTH-1:0]   elem_q
);

    logic [BITWIDTH-1:0] elem_d;

    // No index matches an out-of-range address, so the default zero stands.
    always_comb begin
        elem_d = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(addr) == k) begin
                elem_d = vec_in[k*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            elem_q <= '0;
        end else begin
            elem_q <= elem_d;
        end
    end

endmodule

// File: rtl/gate_sequencer.sv
// Drives one gate step per accepted x_t, serves gate operands, captures h_t.
// Ports: clock, reset (async active-low), bus (gate_sequencer_if.master).
// TIMEOUT bounds the WAIT state; expiry sets the sticky timeoutErr.
module gate_sequencer
    import rnn_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input logic              clock,
    input logic              reset,
    gate_sequencer_if.master bus
);

    localparam int unsigned TMO_W = clog2(TIMEOUT + 1);

    seq_state_t           state_q,    state_d;
    x_vec_t               x_q,        x_d;
    h_vec_t               h_q,        h_d;
    h_vec_t               result_q,   result_d;
    logic [TMO_W-1:0]     cnt_q,      cnt_d;
    logic [COUNT_W-1:0]   count_q,    count_d;
    logic                 clr_pend_q, clr_pend_d;
    logic                 dr_q;
    logic                 begin_q,    begin_d;
    logic                 ready_q,    ready_d;
    logic                 valid_q,    valid_d;
    logic                 busy_q,     busy_d;
    logic                 tmo_q,      tmo_d;

    // Next state, datapath updates and next-state-decoded registered outputs.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        h_d        = h_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        clr_pend_d = clr_pend_q | bus.clearState;
        tmo_d      = tmo_q;

        unique case (state_q)
            IDLE: begin
                // A clear (new or pending) takes the cycle; the sample waits.
                if (clr_pend_q || bus.clearState) begin
                    h_d        = '0;
                    clr_pend_d = 1'b0;
                end else if (bus.sampleValid && ready_q) begin
                    x_d     = bus.sampleIn;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Only a fresh rising edge counts as completion.
                if (bus.dataReady_gate && !dr_q) begin
                    state_d = CAPTURE;
                end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            CAPTURE: begin
                h_d      = bus.gateOutput;
                result_d = bus.gateOutput;
                count_d  = count_q + COUNT_W'(1);
                state_d  = OUT;
            end
            OUT: begin
                if (bus.resultReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        begin_d = (state_d == START);
        ready_d = (state_d == IDLE) && !clr_pend_d;
        valid_d = (state_d == OUT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            h_q        <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            clr_pend_q <= 1'b0;
            dr_q       <= 1'b0;
            begin_q    <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            h_q        <= h_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            clr_pend_q <= clr_pend_d;
            dr_q       <= bus.dataReady_gate;
            begin_q    <= begin_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    // Operand serving runs in every state.
    vector_element_select #(
        .N        (INPUT_SZ),
        .BITWIDTH (BITWIDTH),
        .ADDR_W   (ADDR_BITWIDTH_X)
    ) u_x_sel (
        .clock  (clock),
        .reset  (reset),
        .vec_in (x_q),
        .addr   (bus.colAddress_X),
        .elem_q (bus.inData)
    );

    vector_element_select #(
        .N        (HIDDEN_SZ),
        .BITWIDTH (BITWIDTH),
        .ADDR_W   (ADDR_BITWIDTH)
    ) u_h_sel (
        .clock  (clock),
        .reset  (reset),
        .vec_in (h_q),
        .addr   (bus.colAddress_Y),
        .elem_q (bus.prevOut)
    );

    assign bus.sampleReady = ready_q;
    assign bus.beginCalc   = begin_q;
    assign bus.resultValid = valid_q;
    assign bus.resultOut   = result_q;
    assign bus.busy        = busy_q;
    assign bus.timeoutErr  = tmo_q;
    assign bus.sampleCount = count_q;

endmodule
